// File: rtl/button_debounce_pulse_if.sv
// Button conditioning signal bundle: raw level in, debounced level and event pulses out.
interface button_debounce_pulse_if;
  logic button_raw;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output button_raw,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  button_raw,
    output pressed,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_debounce_pulse.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, registered press/release/long-press pulses.
module button_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter int unsigned CNT_WIDTH       = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  button_debounce_pulse_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 r_s1;
  logic                 r_s2;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_deb_cnt;
  logic [CNT_WIDTH-1:0] r_hold_cnt;
  logic                 r_long_done;
  logic                 r_pressed;
  logic                 r_press_pulse;
  logic                 r_release_pulse;
  logic                 r_long_pulse;

  state_t               w_state;
  logic [CNT_WIDTH-1:0] w_deb_cnt;
  logic [CNT_WIDTH-1:0] w_hold_cnt;
  logic                 w_long_done;
  logic                 w_pressed;
  logic                 w_press_pulse;
  logic                 w_release_pulse;
  logic                 w_long_pulse;
  logic                 w_sync;

  assign w_sync = r_s2;

  always_comb begin
    w_state         = r_state;
    w_deb_cnt       = r_deb_cnt;
    w_hold_cnt      = r_hold_cnt;
    w_long_done     = r_long_done;
    w_pressed       = r_pressed;
    w_press_pulse   = 1'b0;
    w_release_pulse = 1'b0;
    w_long_pulse    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_sync) begin
          w_state   = PRESS_WAIT;
          w_deb_cnt = CNT_ONE;
        end
      end

      PRESS_WAIT: begin
        if (!w_sync) begin
          w_state   = IDLE;
          w_deb_cnt = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state       = HELD;
          w_pressed     = 1'b1;
          w_press_pulse = 1'b1;
          w_hold_cnt    = '0;
          w_long_done   = 1'b0;
          w_deb_cnt     = '0;
        end else begin
          w_deb_cnt = r_deb_cnt + CNT_ONE;
        end
      end

      // Release detection outranks the long-press fire; hold_cnt stays frozen while bouncing.
      HELD: begin
        if (!w_sync) begin
          w_state   = RELEASE_WAIT;
          w_deb_cnt = CNT_ONE;
        end else if (!r_long_done && (r_hold_cnt == LONG_LAST)) begin
          w_long_pulse = 1'b1;
          w_long_done  = 1'b1;
        end else if (!r_long_done) begin
          w_hold_cnt = r_hold_cnt + CNT_ONE;
        end
      end

      RELEASE_WAIT: begin
        if (w_sync) begin
          w_state   = HELD;
          w_deb_cnt = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state         = IDLE;
          w_pressed       = 1'b0;
          w_release_pulse = 1'b1;
          w_hold_cnt      = '0;
          w_long_done     = 1'b0;
          w_deb_cnt       = '0;
        end else begin
          w_deb_cnt = r_deb_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1            <= 1'b0;
      r_s2            <= 1'b0;
      r_state         <= IDLE;
      r_deb_cnt       <= '0;
      r_hold_cnt      <= '0;
      r_long_done     <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
    end else begin
      r_s1            <= bus.button_raw;
      r_s2            <= r_s1;
      r_state         <= w_state;
      r_deb_cnt       <= w_deb_cnt;
      r_hold_cnt      <= w_hold_cnt;
      r_long_done     <= w_long_done;
      r_pressed       <= w_pressed;
      r_press_pulse   <= w_press_pulse;
      r_release_pulse <= w_release_pulse;
      r_long_pulse    <= w_long_pulse;
    end
  end

  assign bus.pressed       = r_pressed;
  assign bus.press_pulse   = r_press_pulse;
  assign bus.release_pulse = r_release_pulse;
  assign bus.long_pulse    = r_long_pulse;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: directed scenarios plus random button traffic against a run-length model.
module tb_button_debounce_pulse;
  localparam int unsigned D = 4;
  localparam int unsigned L = 10;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_debounce_pulse_if bus ();

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .CNT_WIDTH      (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: sync is raw delayed two samples; the debounced level flips once sync has
  // disagreed with it for D consecutive samples; a hold sample counts only while
  // the level is 1 with no pending disagreement run.
  logic       m_h1, m_h2, m_lvl, m_ldone;
  int         m_run, m_hold;
  logic [3:0] m_out;  // {pressed, press, release, long}

  int ecount = 0;
  int n_press, n_rel, n_long, e_press, e_rel, e_long;
  int base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at step %0d", tag, obs, expv, ecount);
    end
  endtask

  task automatic model(input logic raw, input logic r);
    logic sync;
    m_out[2:0] = 3'b000;
    if (r) begin
      m_h1 = 1'b0; m_h2 = 1'b0; m_lvl = 1'b0; m_ldone = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      sync = m_h2;
      m_h2 = m_h1;
      m_h1 = raw;
      if (sync != m_lvl) begin
        m_run++;
        if (m_run == int'(D)) begin
          m_lvl   = sync;
          m_run   = 0;
          m_hold  = 0;
          m_ldone = 1'b0;
          if (sync) m_out[2] = 1'b1;
          else      m_out[1] = 1'b1;
        end
      end else if (m_run != 0) begin
        m_run = 0;
      end else if (m_lvl && !m_ldone) begin
        m_hold++;
        if (m_hold == int'(L)) begin
          m_out[0] = 1'b1;
          m_ldone  = 1'b1;
        end
      end
    end
    m_out[3] = m_lvl;
  endtask

  task automatic step(input logic raw, input logic r);
    logic [3:0] obs;
    bus.button_raw = raw;
    rst = r;
    @(posedge clk);
    model(raw, r);
    #1;
    obs = {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse};
    check("outputs", obs, m_out);
    check("onehot_pulses", $onehot0(obs[2:0]), 1);
    if (obs[2]) begin n_press++; e_press = ecount; end
    if (obs[1]) begin n_rel++;   e_rel   = ecount; end
    if (obs[0]) begin n_long++;  e_long  = ecount; end
    ecount++;
  endtask

  task automatic run(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_long = 0;
    e_press = -1; e_rel = -1; e_long = -1;
    base = ecount;
  endtask

  initial begin
    int unsigned raw_r, len, rr;
    clr();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_outputs", {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse}, 4'b0000);

    // Clean press and hold
    clr();
    run(1'b1, 20);
    check("press_edge", e_press - base, 5);
    check("press_count", n_press, 1);
    check("long_edge", e_long - base, 15);
    check("long_count", n_long, 1);
    check("pressed_held", bus.pressed, 1);

    // Release after long press
    clr();
    run(1'b0, 8);
    check("release_edge", e_rel - base, 5);
    check("release_count", n_rel, 1);
    check("pressed_released", bus.pressed, 0);

    // Glitch of 3 samples is rejected; a 4-sample pulse is judged by the model
    clr();
    run(1'b1, 3);
    run(1'b0, 8);
    check("glitch_no_press", n_press, 0);
    check("glitch_pressed", bus.pressed, 0);
    run(1'b1, 4);
    run(1'b0, 10);

    // Release before long press
    clr();
    run(1'b1, 8);
    base = ecount;
    run(1'b0, 8);
    check("early_release_edge", e_rel - base, 5);
    check("early_release_no_long", n_long, 0);

    // Release bounce at hold count 3
    clr();
    run(1'b1, 7);
    run(1'b0, 2);
    run(1'b1, 20);
    check("bounce_long_edge", e_long - base, 18);
    check("bounce_long_count", n_long, 1);
    check("bounce_no_release", n_rel, 0);
    check("bounce_pressed", bus.pressed, 1);
    run(1'b0, 8);

    // Drop coincides with hold count 9
    clr();
    run(1'b1, 13);
    run(1'b0, 10);
    check("simul_no_long", n_long, 0);
    check("simul_release_count", n_rel, 1);
    check("simul_release_edge", e_rel - base, 18);

    // Reset during PRESS_WAIT with button held
    run(1'b1, 3);
    clr();
    step(1'b1, 1'b1);
    check("rst_pw_outputs", {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse}, 4'b0000);
    clr();
    run(1'b1, 8);
    check("rst_pw_press_edge", e_press - base, 5);

    // Reset during HELD with button held
    step(1'b1, 1'b1);
    check("rst_held_outputs", {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse}, 4'b0000);
    clr();
    run(1'b1, 8);
    check("rst_held_press_edge", e_press - base, 5);
    check("rst_held_press_count", n_press, 1);
    run(1'b0, 8);

    // Random traffic with occasional resets
    for (int s = 0; s < 300; s++) begin
      raw_r = $urandom_range(0, 1);
      len   = $urandom_range(1, 25);
      for (int k = 0; k < int'(len); k++) begin
        rr = $urandom_range(0, 199);
        step(raw_r[0], (rr == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
